// File: rtl/hsv2rgb_pkg.sv
// Shared HSV/RGB pixel-format constants, stage payloads and helpers for the
// hsv2rgb converter and the keyer that produces the same HSV format.
package hsv2rgb_pkg;

    localparam int unsigned LAT_CYC  = 4;
    localparam int unsigned PIX_W    = 24;
    localparam int unsigned HUE_W    = 9;
    localparam int unsigned SAT_W    = 7;
    localparam int unsigned VAL_W    = 8;
    localparam int unsigned CH_W     = 8;
    localparam int unsigned SEC_W    = 3;
    localparam int unsigned FRAC_W   = 6;

    localparam int unsigned HUE_HI   = 23;
    localparam int unsigned HUE_LO   = 15;
    localparam int unsigned SAT_HI   = 14;
    localparam int unsigned SAT_LO   = 8;
    localparam int unsigned VAL_HI   = 7;
    localparam int unsigned VAL_LO   = 0;

    localparam int unsigned R_HI     = 23;
    localparam int unsigned R_LO     = 16;
    localparam int unsigned G_HI     = 15;
    localparam int unsigned G_LO     = 8;
    localparam int unsigned B_HI     = 7;
    localparam int unsigned B_LO     = 0;

    localparam int unsigned HUE_MAX  = 360;
    localparam int unsigned SECTOR_W = 60;
    localparam int unsigned INV60    = 1093;

    typedef struct packed {
        logic              en;
        logic              valid;
        logic [PIX_W-1:0]  pass;
        logic [PIX_W-1:0]  raw;
        logic [SEC_W-1:0]  sec;
        logic [FRAC_W-1:0] frac;
        logic [SAT_W-1:0]  sat;
        logic [VAL_W-1:0]  val;
    } s1_t;

    typedef struct packed {
        logic              en;
        logic              valid;
        logic [PIX_W-1:0]  pass;
        logic [PIX_W-1:0]  raw;
        logic [SEC_W-1:0]  sec;
        logic [VAL_W-1:0]  val;
        logic [CH_W-1:0]   c;
        logic [FRAC_W-1:0] k;
    } s2_t;

    typedef struct packed {
        logic              en;
        logic              valid;
        logic [PIX_W-1:0]  pass;
        logic [PIX_W-1:0]  raw;
        logic [SEC_W-1:0]  sec;
        logic [CH_W-1:0]   c;
        logic [CH_W-1:0]   x;
        logic [CH_W-1:0]   m;
    } s3_t;

    typedef struct packed {
        logic              valid;
        logic [PIX_W-1:0]  pass;
        logic [PIX_W-1:0]  pix;
    } out_t;

    // Channel add clamped to full scale.
    function automatic logic [CH_W-1:0] sat_add(input logic [CH_W-1:0] a,
                                                input logic [CH_W-1:0] b);
        logic [CH_W:0] sum;
        sum = (CH_W+1)'(a) + (CH_W+1)'(b);
        return sum[CH_W] ? {CH_W{1'b1}} : sum[CH_W-1:0];
    endfunction

endpackage

// File: rtl/hsv2rgb_hue_sector.sv
// Combinational hue decode: wrap 360..511 back into range, then split the
// hue into a 60-degree sector index and the offset within that sector.
module hue_sector
    import hsv2rgb_pkg::*;
(
    input  logic [HUE_W-1:0]  hue,
    output logic [HUE_W-1:0]  hue_wrap_c,
    output logic [SEC_W-1:0]  sector_c,
    output logic [FRAC_W-1:0] frac_c
);

    logic [HUE_W-1:0] base;

    always_comb begin
        hue_wrap_c = hue;
        sector_c   = '0;
        base       = '0;
        if (hue >= HUE_W'(HUE_MAX)) begin
            hue_wrap_c = hue - HUE_W'(HUE_MAX);
        end
        // Compare chain against sector starts; last match wins.
        for (int unsigned i = 1; i < 6; i++) begin
            if (hue_wrap_c >= HUE_W'(i * SECTOR_W)) begin
                sector_c = SEC_W'(i);
                base     = HUE_W'(i * SECTOR_W);
            end
        end
        frac_c = FRAC_W'(hue_wrap_c - base);
    end

endmodule

// File: rtl/hsv2rgb.sv
// Four-stage HSV-to-RGB converter with bypass, sideband and valid tag
// delay-matched to the pixel.
module hsv2rgb
    import hsv2rgb_pkg::*;
#(
    parameter int unsigned LAT = LAT_CYC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hsv_en,
    input  logic             valid_in,
    input  logic [PIX_W-1:0] pixel_in,
    input  logic [PIX_W-1:0] pass_in,
    output logic [PIX_W-1:0] pixel_out,
    output logic [PIX_W-1:0] pass_thru,
    output logic             valid_out
);

    if (LAT != LAT_CYC) begin : g_lat_fixed
        $error("hsv2rgb pipeline depth is fixed at 4");
    end

    s1_t  s1_d,  s1_q;
    s2_t  s2_d,  s2_q;
    s3_t  s3_d,  s3_q;
    out_t out_d, out_q;

    logic [HUE_W-1:0]  hue_wrap_unused;
    logic [SEC_W-1:0]  sector_c;
    logic [FRAC_W-1:0] frac_c;

    hue_sector u_hue_sector (
        .hue        (pixel_in[HUE_HI:HUE_LO]),
        .hue_wrap_c (hue_wrap_unused),
        .sector_c   (sector_c),
        .frac_c     (frac_c)
    );

    always_comb begin
        s1_d       = '0;
        s1_d.en    = hsv_en;
        s1_d.valid = valid_in;
        s1_d.pass  = pass_in;
        s1_d.raw   = pixel_in;
        s1_d.sec   = sector_c;
        s1_d.frac  = frac_c;
        s1_d.sat   = pixel_in[SAT_HI:SAT_LO];
        s1_d.val   = pixel_in[VAL_HI:VAL_LO];
    end

    // Chroma c = v*s_sc/128; k is the distance into the sector ramp.
    logic [CH_W-1:0]   s_sc;
    logic [15:0]       vs;
    always_comb begin
        s_sc       = CH_W'(s1_q.sat) + CH_W'(s1_q.sat >> 6);
        vs         = 16'(s1_q.val) * 16'(s_sc);
        s2_d       = '0;
        s2_d.en    = s1_q.en;
        s2_d.valid = s1_q.valid;
        s2_d.pass  = s1_q.pass;
        s2_d.raw   = s1_q.raw;
        s2_d.sec   = s1_q.sec;
        s2_d.val   = s1_q.val;
        s2_d.c     = CH_W'(vs >> 7);
        s2_d.k     = s1_q.sec[0] ? FRAC_W'(SECTOR_W) - s1_q.frac : s1_q.frac;
    end

    // x = c*k/60 via reciprocal multiply by 1093/65536.
    logic [13:0] ck;
    logic [24:0] ck_inv;
    logic [8:0]  x_full;
    always_comb begin
        ck         = 14'(s2_q.c) * 14'(s2_q.k);
        ck_inv     = 25'(ck) * 25'(INV60);
        x_full     = 9'(ck_inv >> 16);
        s3_d       = '0;
        s3_d.en    = s2_q.en;
        s3_d.valid = s2_q.valid;
        s3_d.pass  = s2_q.pass;
        s3_d.raw   = s2_q.raw;
        s3_d.sec   = s2_q.sec;
        s3_d.c     = s2_q.c;
        s3_d.x     = x_full[8] ? {CH_W{1'b1}} : x_full[CH_W-1:0];
        s3_d.m     = s2_q.val - s2_q.c;
    end

    logic [CH_W-1:0] r_c, g_c, b_c;
    always_comb begin
        r_c = '0;
        g_c = '0;
        b_c = '0;
        unique case (s3_q.sec)
            3'd0:    begin r_c = s3_q.c; g_c = s3_q.x;                  end
            3'd1:    begin r_c = s3_q.x; g_c = s3_q.c;                  end
            3'd2:    begin               g_c = s3_q.c; b_c = s3_q.x;    end
            3'd3:    begin               g_c = s3_q.x; b_c = s3_q.c;    end
            3'd4:    begin r_c = s3_q.x;               b_c = s3_q.c;    end
            3'd5:    begin r_c = s3_q.c;               b_c = s3_q.x;    end
            default: begin                                              end
        endcase
        out_d       = '0;
        out_d.valid = s3_q.valid;
        out_d.pass  = s3_q.pass;
        out_d.pix   = s3_q.en ? {sat_add(r_c, s3_q.m),
                                 sat_add(g_c, s3_q.m),
                                 sat_add(b_c, s3_q.m)}
                              : s3_q.raw;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q  <= '0;
            s2_q  <= '0;
            s3_q  <= '0;
            out_q <= '0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            s3_q  <= s3_d;
            out_q <= out_d;
        end
    end

    assign pixel_out = out_q.pix;
    assign pass_thru = out_q.pass;
    assign valid_out = out_q.valid;

endmodule

// File: doc/hsv2rgb.md
Name: hsv2rgb

Overview:
- Pipelined HSV-to-RGB converter. It is the decode end of the HSV pixel format that the green-screen keyer consumes and produces.
- Sits after the keyer and effect stages, ahead of the VGA/LCD output, so keyed HSV pixels reach the display as 8:8:8 RGB.
- Fixed 4-cycle latency. Sideband word and valid flag are delay-matched to the pixel.

Parameters:
- LAT, 4, pipeline depth in cycles. Fixed; exposed only so upstream delay-matching logic can reference it.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- hsv_en  in  1  1 = convert; 0 = pass pixel_in unchanged with the same latency
- valid_in  in  1  pixel_in/pass_in qualify this cycle
- pixel_in  in  24  HSV: hue[23:15] (0..359), sat[14:8] (0..127), val[7:0] (0..255)
- pass_in  in  24  sideband (row/col/sync), not interpreted
- pixel_out  out  24  RGB: R[23:16], G[15:8], B[7:0]
- pass_thru  out  24  pass_in delayed LAT cycles
- valid_out  out  1  valid_in delayed LAT cycles

Behaviour:
- Reset: clk and rst_n as above; reset is asynchronous and active-low. Every pipeline register is cleared: pixel_out=0, pass_thru=0, valid_out=0, hsv_en copies=0.
- No stall or backpressure. All stages advance every clk. valid is carried only as a tag; invalid pixels are still computed and are don't-care downstream.
- hsv_en is sampled with the pixel in stage 1 and carried down the pipe, so a toggle affects only pixels entering on or after that cycle.
- Latency: an input on edge N appears at pixel_out, pass_thru and valid_out after edge N+4. Throughput is 1 pixel/clk.
- S1:
  - Register v, s and raw.
  - Hue wrap: h' = h-360 if h >= 360, else h. Covers 360..511.
  - sector = floor(h'/60), 0..5, computed by a compare chain (no divider).
  - f = h' - 60*sector, 0..59.
- S2:
  - s_sc = s + (s>>6), so s=127 maps to 128.
  - c = (v*s_sc)>>7, 8 bits, c <= v.
  - k = f if sector is even, else 60-f. k ranges 0..60.
  - Forward sector and v.
- S3:
  - x = (c*k*1093)>>16. This approximates c*k/60 and saturates at 255.
  - m = v - c, which never goes negative.
  - Forward c and sector.
- S4: sector -> (R,G,B) before adding m:
  - 0 -> (c,x,0)
  - 1 -> (x,c,0)
  - 2 -> (0,c,x)
  - 3 -> (0,x,c)
  - 4 -> (x,0,c)
  - 5 -> (c,0,x)
  - Each channel is (channel+m) clamped to 255.
  - Registered output: if hsv_en copy=0, output the raw pixel instead.
- Intermediate widths:
  - v*s_sc: 16 bits
  - c*k: 14 bits
  - c*k*1093: 25 bits
- Reset mid-stream: in-flight pixels are discarded. valid_out stays 0 for 4 cycles after rst_n rises, even if valid_in was high throughout.
- Gray axis: s=0 gives c=0, x=0, so all three channels equal v regardless of hue.

Decomposition:
- Shared pixel package holds:
  - HSV field ranges: HUE_HI=23, HUE_LO=15, SAT_HI=14, SAT_LO=8, VAL_HI=7, VAL_LO=0.
  - RGB field ranges.
  - Constants HUE_MAX=360, SECTOR_W=60, INV60=1093.
  - The keyer uses the same field constants.
- One sub-module, hue_sector: combinational h -> (h' wrap, sector, f). It is instantiated in S1 and reusable by other hue-based effects.

Test Plan:
- Primary colours, s=127, v=255:
  - h=0 -> FF0000
  - h=120 -> 00FF00
  - h=240 -> 0000FF
  - Each appears exactly 4 clk after input, with valid_out matching.
- Sector boundary/mid:
  - h=60,s=127,v=255 -> FFFF00
  - h=30,s=127,v=200 -> C86400 (x=100)
  - h=300,s=127,v=255 -> FF00FF
- Gray/wrap:
  - s=0,v=128,h=200 -> 808080
  - h=400,s=127,v=255 converts identically to h=40 -> FFAA00
- Bypass: hsv_en=0, pixel_in=123456 -> pixel_out=123456 at +4. Toggling hsv_en on consecutive pixels switches per pixel with no bleed.
- Streaming/sideband: 16 back-to-back valid pixels with pass_in=row/col counter -> pass_thru sequence matches input delayed 4. One gap in valid_in shows as one gap in valid_out.
- Reset: assert rst_n=0 for 1 cycle mid-stream -> all outputs 0 immediately, asynchronously. After release, valid_out=0 for 4 cycles, then the new stream appears correctly.
